// File: rtl/board_arbiter_pkg.sv
// rtl/board_arbiter_pkg.sv - board geometry, FSM state types and cell addressing helpers
package board_arbiter_pkg;

  localparam int WORD_SIZE      = 16;
  localparam int LOG_WORD_SIZE  = 4;
  localparam int LOG_BOARD_SIZE = 6;
  localparam int BOARD_SIZE     = 1 << LOG_BOARD_SIZE;
  localparam int WORDS_PER_ROW  = BOARD_SIZE / WORD_SIZE;
  localparam int LOG_MAX_ADDR   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    READY = 2'd2
  } gen_state_t;

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_RD   = 2'd1,
    E_WAIT = 2'd2,
    E_WR   = 2'd3
  } edit_state_t;

  function automatic logic [LOG_MAX_ADDR-1:0] cell_word_addr(
    input logic [LOG_BOARD_SIZE-1:0] x,
    input logic [LOG_BOARD_SIZE-1:0] y
  );
    logic [31:0] a;
    a = 32'(y) * 32'(WORDS_PER_ROW) + (32'(x) >> LOG_WORD_SIZE);
    return a[LOG_MAX_ADDR-1:0];
  endfunction

  // Leftmost cell lives in the MSB, so bit index is the complement of x's low bits.
  function automatic logic [WORD_SIZE-1:0] cell_mask(
    input logic [LOG_BOARD_SIZE-1:0] x
  );
    logic [WORD_SIZE-1:0] m;
    logic [LOG_WORD_SIZE-1:0] b;
    b    = ~x[LOG_WORD_SIZE-1:0];
    m    = '0;
    m[b] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/board_arbiter_cell_toggle_rmw.sv
// rtl/board_arbiter_cell_toggle_rmw.sv - read-modify-write sequencer toggling one board cell
module cell_toggle_rmw
  import board_arbiter_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      edit_req_i,
  input  logic [LOG_BOARD_SIZE-1:0] edit_x_i,
  input  logic [LOG_BOARD_SIZE-1:0] edit_y_i,
  input  logic                      render_done_i,
  input  logic                      gen_idle_i,
  input  logic [WORD_SIZE-1:0]      front_dout_i,
  output edit_state_t               state_o,
  output logic                      start_o,
  output logic [LOG_MAX_ADDR-1:0]   addr_o,
  output logic [WORD_SIZE-1:0]      wdata_o,
  output logic                      we_o,
  output logic                      ack_o
);

  edit_state_t             state_q;
  logic [LOG_MAX_ADDR-1:0] addr_q;
  logic [WORD_SIZE-1:0]    mask_q;
  logic [WORD_SIZE-1:0]    wdata_q;
  logic                    we_q;
  logic                    ack_q;

  assign start_o = (state_q == E_IDLE) & edit_req_i & render_done_i & gen_idle_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= E_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        E_IDLE: begin
          if (start_o) begin
            addr_q  <= cell_word_addr(edit_x_i, edit_y_i);
            mask_q  <= cell_mask(edit_x_i);
            state_q <= E_RD;
          end
        end
        E_RD: begin
          // The address only reaches the port while blanking; otherwise keep waiting.
          if (render_done_i) state_q <= E_WAIT;
        end
        E_WAIT: begin
          if (!render_done_i) begin
            state_q <= E_RD;
          end else begin
            wdata_q <= front_dout_i ^ mask_q;
            we_q    <= 1'b1;
            state_q <= E_WR;
          end
        end
        E_WR: begin
          we_q    <= 1'b0;
          ack_q   <= 1'b1;
          state_q <= E_IDLE;
        end
        default: state_q <= E_IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign we_o    = we_q;
  assign ack_o   = ack_q;

endmodule

// File: rtl/board_arbiter.sv
// rtl/board_arbiter.sv - front/back board buffer arbiter and generation sequencer (option: BOARD_ARBITER_AUTO_STEP_EN)
module board_arbiter
  import board_arbiter_pkg::*;
#(
  parameter int STEP_FRAMES = 30,
  parameter int GEN_W       = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      render_done_in,
  input  logic [LOG_MAX_ADDR-1:0]   render_addr_in,
  output logic [WORD_SIZE-1:0]      render_data_out,
  output logic                      upd_start_out,
  input  logic                      upd_done_in,
  input  logic [LOG_MAX_ADDR-1:0]   upd_addr_r_in,
  output logic                      upd_grant_out,
  output logic                      upd_valid_out,
  output logic [WORD_SIZE-1:0]      upd_data_r_out,
  input  logic [LOG_MAX_ADDR-1:0]   upd_addr_w_in,
  input  logic [WORD_SIZE-1:0]      upd_data_w_in,
  input  logic                      upd_we_in,
  input  logic                      edit_req_in,
  input  logic [LOG_BOARD_SIZE-1:0] edit_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] edit_y_in,
  output logic                      edit_ack_out,
  input  logic                      step_in,
  input  logic                      run_in,
  output logic [LOG_MAX_ADDR-1:0]   mem_a_addr_out,
  output logic [WORD_SIZE-1:0]      mem_a_din_out,
  output logic                      mem_a_we_out,
  input  logic [WORD_SIZE-1:0]      mem_a_dout_in,
  output logic [LOG_MAX_ADDR-1:0]   mem_b_addr_out,
  output logic [WORD_SIZE-1:0]      mem_b_din_out,
  output logic                      mem_b_we_out,
  input  logic [WORD_SIZE-1:0]      mem_b_dout_in,
  output logic                      front_sel_out,
  output logic [GEN_W-1:0]          gen_count_out
);

  gen_state_t              gen_state_q;
  logic                    front_sel_q;
  logic                    rd_sel_q;
  logic [GEN_W-1:0]        gen_count_q;
  logic                    upd_start_q;
  logic                    upd_valid_q;
  logic                    pending_q;
  logic                    pending_d;
  logic                    step_set;
  logic                    gen_go;

  edit_state_t             edit_state;
  logic                    edit_idle;
  logic                    edit_start;
  logic [LOG_MAX_ADDR-1:0] edit_addr;
  logic [WORD_SIZE-1:0]    edit_wdata;
  logic                    edit_we;

  logic [LOG_MAX_ADDR-1:0] front_addr;
  logic [WORD_SIZE-1:0]    front_dout;
  logic                    back_we;

  cell_toggle_rmw u_rmw (
    .clk_i         (clk_in),
    .rst_n_i       (rst_n_in),
    .edit_req_i    (edit_req_in),
    .edit_x_i      (edit_x_in),
    .edit_y_i      (edit_y_in),
    .render_done_i (render_done_in),
    .gen_idle_i    (gen_state_q == IDLE),
    .front_dout_i  (front_dout),
    .state_o       (edit_state),
    .start_o       (edit_start),
    .addr_o        (edit_addr),
    .wdata_o       (edit_wdata),
    .we_o          (edit_we),
    .ack_o         (edit_ack_out)
  );

  assign edit_idle = (edit_state == E_IDLE);

`ifdef BOARD_ARBITER_AUTO_STEP_EN
  localparam int CNT_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(STEP_FRAMES - 1);

  logic [CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0] frame_cnt_d;
  logic             render_done_q;
  logic             auto_step;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    auto_step   = 1'b0;
    if (!run_in) begin
      frame_cnt_d = '0;
    end else if (render_done_in && !render_done_q) begin
      if (frame_cnt_q == LAST_FRAME) begin
        frame_cnt_d = '0;
        auto_step   = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_cnt_q   <= '0;
      render_done_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      render_done_q <= render_done_in;
    end
  end

  assign step_set = step_in | auto_step;
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = {run_in, 31'(STEP_FRAMES)};
  assign step_set   = step_in;
`endif

  // An edit accepted this cycle takes precedence over starting a generation.
  assign gen_go    = (gen_state_q == IDLE) & pending_q & edit_idle & ~edit_start;
  assign pending_d = step_set | (pending_q & ~gen_go);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      gen_state_q <= IDLE;
      front_sel_q <= 1'b0;
      rd_sel_q    <= 1'b0;
      gen_count_q <= '0;
      upd_start_q <= 1'b0;
      upd_valid_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      upd_start_q <= 1'b0;
      upd_valid_q <= upd_grant_out;
      rd_sel_q    <= front_sel_q;
      pending_q   <= pending_d;
      case (gen_state_q)
        IDLE: begin
          if (gen_go) begin
            gen_state_q <= RUN;
            upd_start_q <= 1'b1;
          end
        end
        RUN: begin
          if (upd_done_in) gen_state_q <= READY;
        end
        READY: begin
          if (render_done_in && edit_idle) begin
            gen_state_q <= IDLE;
            front_sel_q <= ~front_sel_q;
            gen_count_q <= gen_count_q + 1'b1;
          end
        end
        default: gen_state_q <= IDLE;
      endcase
    end
  end

  // The edit write cycle steals the port even from an active renderer.
  always_comb begin
    front_addr = upd_addr_r_in;
    if (edit_state == E_WR)       front_addr = edit_addr;
    else if (!render_done_in)     front_addr = render_addr_in;
    else if (!edit_idle)          front_addr = edit_addr;
  end

  assign upd_grant_out = render_done_in & edit_idle & (gen_state_q == RUN);
  assign back_we       = upd_we_in & (gen_state_q == RUN);

  assign mem_a_addr_out = front_sel_q ? upd_addr_w_in : front_addr;
  assign mem_a_din_out  = front_sel_q ? upd_data_w_in : edit_wdata;
  assign mem_a_we_out   = front_sel_q ? back_we       : edit_we;
  assign mem_b_addr_out = front_sel_q ? front_addr    : upd_addr_w_in;
  assign mem_b_din_out  = front_sel_q ? edit_wdata    : upd_data_w_in;
  assign mem_b_we_out   = front_sel_q ? edit_we       : back_we;

  // Read data returns a cycle after the address, so steer it with the select of that cycle.
  assign front_dout      = rd_sel_q ? mem_b_dout_in : mem_a_dout_in;
  assign render_data_out = front_dout;
  assign upd_data_r_out  = front_dout;

  assign upd_start_out = upd_start_q;
  assign upd_valid_out = upd_valid_q;
  assign front_sel_out = front_sel_q;
  assign gen_count_out = gen_count_q;

endmodule

// File: tb/tb_board_arbiter.sv
// tb/tb_board_arbiter.sv - directed self-checking bench for board_arbiter
module tb_board_arbiter;
  import board_arbiter_pkg::*;

  logic                      clk_in = 1'b0;
  logic                      rst_n_in;
  logic                      render_done_in;
  logic [LOG_MAX_ADDR-1:0]   render_addr_in;
  logic [WORD_SIZE-1:0]      render_data_out;
  logic                      upd_start_out;
  logic                      upd_done_in;
  logic [LOG_MAX_ADDR-1:0]   upd_addr_r_in;
  logic                      upd_grant_out;
  logic                      upd_valid_out;
  logic [WORD_SIZE-1:0]      upd_data_r_out;
  logic [LOG_MAX_ADDR-1:0]   upd_addr_w_in;
  logic [WORD_SIZE-1:0]      upd_data_w_in;
  logic                      upd_we_in;
  logic                      edit_req_in;
  logic [LOG_BOARD_SIZE-1:0] edit_x_in;
  logic [LOG_BOARD_SIZE-1:0] edit_y_in;
  logic                      edit_ack_out;
  logic                      step_in;
  logic                      run_in;
  logic [LOG_MAX_ADDR-1:0]   mem_a_addr_out;
  logic [WORD_SIZE-1:0]      mem_a_din_out;
  logic                      mem_a_we_out;
  logic [WORD_SIZE-1:0]      mem_a_dout_in;
  logic [LOG_MAX_ADDR-1:0]   mem_b_addr_out;
  logic [WORD_SIZE-1:0]      mem_b_din_out;
  logic                      mem_b_we_out;
  logic [WORD_SIZE-1:0]      mem_b_dout_in;
  logic                      front_sel_out;
  logic [15:0]               gen_count_out;

  logic [WORD_SIZE-1:0] mem_a [0:255];
  logic [WORD_SIZE-1:0] mem_b [0:255];

  int errors = 0;
  int checks = 0;
  int n_start, n_ack, n_awe, n_bwe;
  int ack_cycle;
  bit auto_done;

  board_arbiter #(.STEP_FRAMES(2), .GEN_W(16)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .render_done_in  (render_done_in),
    .render_addr_in  (render_addr_in),
    .render_data_out (render_data_out),
    .upd_start_out   (upd_start_out),
    .upd_done_in     (upd_done_in),
    .upd_addr_r_in   (upd_addr_r_in),
    .upd_grant_out   (upd_grant_out),
    .upd_valid_out   (upd_valid_out),
    .upd_data_r_out  (upd_data_r_out),
    .upd_addr_w_in   (upd_addr_w_in),
    .upd_data_w_in   (upd_data_w_in),
    .upd_we_in       (upd_we_in),
    .edit_req_in     (edit_req_in),
    .edit_x_in       (edit_x_in),
    .edit_y_in       (edit_y_in),
    .edit_ack_out    (edit_ack_out),
    .step_in         (step_in),
    .run_in          (run_in),
    .mem_a_addr_out  (mem_a_addr_out),
    .mem_a_din_out   (mem_a_din_out),
    .mem_a_we_out    (mem_a_we_out),
    .mem_a_dout_in   (mem_a_dout_in),
    .mem_b_addr_out  (mem_b_addr_out),
    .mem_b_din_out   (mem_b_din_out),
    .mem_b_we_out    (mem_b_we_out),
    .mem_b_dout_in   (mem_b_dout_in),
    .front_sel_out   (front_sel_out),
    .gen_count_out   (gen_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Board BRAM models: loaded with a known pattern while reset is held.
  always @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= (i == 4) ? 16'h0000 : (16'hA000 | 16'(i));
        mem_b[i] <= 16'hB000 | 16'(i);
      end
    end else begin
      if (mem_a_we_out) mem_a[mem_a_addr_out] <= mem_a_din_out;
      if (mem_b_we_out) mem_b[mem_b_addr_out] <= mem_b_din_out;
    end
    mem_a_dout_in <= mem_a[mem_a_addr_out];
    mem_b_dout_in <= mem_b[mem_b_addr_out];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #2;
    if (upd_start_out) n_start++;
    if (edit_ack_out)  n_ack++;
    if (mem_a_we_out)  n_awe++;
    if (mem_b_we_out)  n_bwe++;
    upd_done_in = auto_done && upd_start_out;
  endtask

  initial begin
    rst_n_in = 1'b0; render_done_in = 1'b0; render_addr_in = '0; upd_done_in = 1'b0;
    upd_addr_r_in = '0; upd_addr_w_in = '0; upd_data_w_in = '0; upd_we_in = 1'b1;
    edit_req_in = 1'b0; edit_x_in = '0; edit_y_in = '0; step_in = 1'b0; run_in = 1'b0;
    auto_done = 1'b0; n_start = 0; n_ack = 0; n_awe = 0; n_bwe = 0; ack_cycle = 0;

    cyc(); cyc();
    #1;
    check("rst_front_sel", 32'(front_sel_out), 32'd0);
    check("rst_gen_count", 32'(gen_count_out), 32'd0);
    check("rst_upd_start", 32'(upd_start_out), 32'd0);
    check("rst_upd_valid", 32'(upd_valid_out), 32'd0);
    check("rst_edit_ack",  32'(edit_ack_out),  32'd0);
    check("rst_a_we",      32'(mem_a_we_out),  32'd0);
    check("rst_b_we_drop", 32'(mem_b_we_out),  32'd0);
    rst_n_in = 1'b1;
    upd_we_in = 1'b0;

    // Renderer owns the front port while drawing.
    render_addr_in = 8'd5;
    #1;
    check("render_addr_a", 32'(mem_a_addr_out), 32'd5);
    cyc();
    check("render_data_a", 32'(render_data_out), 32'hA005);

    // Edit x=3,y=1 on word 0x0000 -> word 4 becomes 0x1000.
    render_done_in = 1'b1; edit_x_in = 6'd3; edit_y_in = 6'd1; edit_req_in = 1'b1;
    n_ack = 0; n_awe = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 1) check("edit_rd_addr", 32'(mem_a_addr_out), 32'd4);
      if (k == 3) begin
        check("edit_wr_we",   32'(mem_a_we_out),  32'd1);
        check("edit_wr_addr", 32'(mem_a_addr_out), 32'd4);
        check("edit_wr_data", 32'(mem_a_din_out), 32'h1000);
      end
      if (edit_ack_out) begin
        ack_cycle   = k;
        edit_req_in = 1'b0;
      end
    end
    check("edit_ack_latency", 32'(ack_cycle), 32'd4);
    check("edit_ack_count",   32'(n_ack), 32'd1);
    check("edit_mem_word",    32'(mem_a[4]), 32'h1000);

    // Back writes are dropped outside RUN.
    upd_we_in = 1'b1; upd_addr_w_in = 8'd7; upd_data_w_in = 16'hBEEF;
    #1;
    check("back_we_idle_drop", 32'(mem_b_we_out), 32'd0);
    upd_we_in = 1'b0;

    // Single step, update, swap on blanking.
    n_start = 0;
    step_in = 1'b1;
    cyc();
    step_in = 1'b0;
    upd_addr_r_in = 8'd3;
    cyc();
    check("step_start_pulse", 32'(upd_start_out), 32'd1);
    check("step_grant",       32'(upd_grant_out), 32'd1);
    cyc();
    check("upd_start_one_cycle", 32'(upd_start_out), 32'd0);
    check("upd_valid",           32'(upd_valid_out), 32'd1);
    check("upd_data_r",          32'(upd_data_r_out), 32'hA003);
    upd_we_in = 1'b1;
    #1;
    check("back_we_run",   32'(mem_b_we_out),   32'd1);
    check("back_addr_run", 32'(mem_b_addr_out), 32'd7);
    cyc();
    upd_we_in = 1'b0;
    for (int k = 0; k < 7; k++) cyc();
    upd_done_in = 1'b1; render_done_in = 1'b0;
    cyc();
    check("ready_no_grant", 32'(upd_grant_out), 32'd0);
    cyc();
    check("no_swap_while_drawing", 32'(front_sel_out), 32'd0);
    render_done_in = 1'b1;
    cyc();
    check("swap_front_sel", 32'(front_sel_out), 32'd1);
    check("swap_gen_count", 32'(gen_count_out), 32'd1);
    check("single_start",   32'(n_start), 32'd1);
    render_done_in = 1'b0; render_addr_in = 8'd7;
    #1;
    check("render_addr_b", 32'(mem_b_addr_out), 32'd7);
    cyc();
    check("render_data_b", 32'(render_data_out), 32'hBEEF);

    // Edit held off while RUN, then lands in the new front buffer (A).
    render_done_in = 1'b1;
    step_in = 1'b1;
    cyc();
    step_in = 1'b0;
    cyc();
    n_ack = 0; n_bwe = 0; n_awe = 0;
    edit_x_in = 6'd0; edit_y_in = 6'd0; edit_req_in = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    check("run_edit_no_ack", 32'(n_ack), 32'd0);
    check("run_edit_no_we",  32'(n_awe + n_bwe), 32'd0);
    upd_done_in = 1'b1;
    cyc();
    cyc();
    check("swap2_front_sel", 32'(front_sel_out), 32'd0);
    check("swap2_gen_count", 32'(gen_count_out), 32'd2);
    for (int k = 0; k < 10 && n_ack == 0; k++) cyc();
    edit_req_in = 1'b0;
    check("post_swap_ack",  32'(n_ack), 32'd1);
    check("post_swap_mem_a", 32'(mem_a[0]), 32'h2000);
    check("post_swap_mem_b", 32'(mem_b[0]), 32'hB000);

    // Blanking ends during E_WAIT: abort, retry next blanking, single write and ack.
    cyc();
    n_ack = 0; n_awe = 0;
    edit_x_in = 6'd17; edit_y_in = 6'd2; edit_req_in = 1'b1;
    cyc();
    check("abort_rd_addr", 32'(mem_a_addr_out), 32'd9);
    cyc();
    render_done_in = 1'b0;
    cyc(); cyc(); cyc();
    check("abort_no_we",  32'(n_awe), 32'd0);
    check("abort_no_ack", 32'(n_ack), 32'd0);
    render_done_in = 1'b1;
    for (int k = 0; k < 10 && n_ack == 0; k++) cyc();
    edit_req_in = 1'b0;
    cyc(); cyc();
    check("retry_ack_count", 32'(n_ack), 32'd1);
    check("retry_we_count",  32'(n_awe), 32'd1);
    check("retry_mem_word",  32'(mem_a[9]), 32'hE009);

    // Six frames with run_in=1 and STEP_FRAMES=2.
    auto_done = 1'b1; run_in = 1'b1; n_start = 0;
    for (int f = 0; f < 6; f++) begin
      render_done_in = 1'b0;
      for (int k = 0; k < 4; k++) cyc();
      render_done_in = 1'b1;
      for (int k = 0; k < 6; k++) cyc();
    end
    run_in = 1'b0;
    for (int k = 0; k < 10; k++) cyc();
`ifdef BOARD_ARBITER_AUTO_STEP_EN
    check("auto_step_starts", 32'(n_start), 32'd3);
    check("auto_step_gen",    32'(gen_count_out), 32'd5);
`else
    check("run_ignored_starts", 32'(n_start), 32'd0);
    check("run_ignored_gen",    32'(gen_count_out), 32'd2);
`endif

    // Asynchronous reset mid-operation.
    #1;
    rst_n_in = 1'b0;
    #1;
    check("async_rst_front_sel", 32'(front_sel_out), 32'd0);
    check("async_rst_gen_count", 32'(gen_count_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_arbiter.md
# board_arbiter

Owns the two board memories (A/B) and multiplexes their ports between the renderer, the generation updater and user cell edits. The front buffer holds the displayed generation and the back buffer receives the next one. The block sequences each generation step (start, complete, swap) so swaps happen only during blanking. It sits between the board BRAMs and the renderer/updater, directly upstream of the renderer's `data_in`.

## Interface
Parameters
- `STEP_FRAMES`, 30: frames between automatic steps (`AUTO_STEP_EN` only); must be ≥1.
- `GEN_W`, 16: width of the generation counter.

Ports
- `clk_in` in 1: single clock for all logic.
- `rst_n_in` in 1: reset, asynchronous, active-low.
- `render_done_in` in 1: renderer blanking flag (renderer `done_out`).
- `render_addr_in` in `LOG_MAX_ADDR`: renderer read address.
- `render_data_out` out `WORD_SIZE`: front-buffer read data.
- `upd_start_out` out 1: one-cycle pulse starting the updater.
- `upd_done_in` in 1: updater finished writing the back buffer.
- `upd_addr_r_in` in `LOG_MAX_ADDR`: updater front-buffer read address.
- `upd_grant_out` out 1: front port serves `upd_addr_r_in` this cycle.
- `upd_valid_out` out 1: `upd_data_r_out` is valid; equals `upd_grant_out` delayed one cycle.
- `upd_data_r_out` out `WORD_SIZE`: front-buffer read data.
- `upd_addr_w_in` in `LOG_MAX_ADDR`, `upd_data_w_in` in `WORD_SIZE`, `upd_we_in` in 1: back-buffer write.
- `edit_req_in` in 1, `edit_x_in` in `LOG_BOARD_SIZE`, `edit_y_in` in `LOG_BOARD_SIZE`: toggle-cell request (level, held until ack).
- `edit_ack_out` out 1: one-cycle pulse when the toggle has been written.
- `step_in` in 1: single-step pulse.
- `run_in` in 1: enables auto-stepping.
- `mem_a_addr_out` / `mem_b_addr_out` out `LOG_MAX_ADDR`; `mem_a_din_out` / `mem_b_din_out` out `WORD_SIZE`; `mem_a_we_out` / `mem_b_we_out` out 1: memory ports.
- `mem_a_dout_in` / `mem_b_dout_in` in `WORD_SIZE`: memory read data, valid 1 cycle after the address.
- `front_sel_out` out 1: 0 means A is the front buffer.
- `gen_count_out` out `GEN_W`: completed swaps, wraps modulo 2^`GEN_W`.

## Operation
- Reset values: `front_sel_out`=0, `gen_count_out`=0, pulses and valid=0, both `we`=0. Gen FSM=IDLE, edit FSM=E_IDLE, step pending=0, frame counter=0.
- **Front port address (combinational), in priority order:**
  - `render_done_in`=0: renderer address.
  - Edit FSM ≠ E_IDLE: edit address.
  - Otherwise: `upd_addr_r_in`.
- `upd_grant_out` = `render_done_in` & edit E_IDLE & gen RUN. Without a grant, the updater holds its address.
- **Back port:** address = `upd_addr_w_in`, din = `upd_data_w_in`, we = `upd_we_in` & gen RUN. Writes in any other state are dropped.
- `render_data_out` and `upd_data_r_out` both carry the front `dout`.
- **Gen FSM:**
  - IDLE → RUN when step pending & edit E_IDLE. Pulse `upd_start_out` and clear pending on that transition.
  - RUN → READY on `upd_done_in`.
  - READY → IDLE on the first cycle with `render_done_in`=1 & edit E_IDLE. That cycle toggles `front_sel_out` and increments `gen_count_out`.
- **Step pending:** set by `step_in`. Holds at most one pending step; further steps are dropped while it is set. A set and a clear in the same cycle leaves it set.
- **Edit FSM** (accepts only while gen is IDLE, so edits cannot be lost on a swap):
  - E_IDLE → E_RD when `edit_req_in` & `render_done_in` & gen IDLE. Presents the word address `y*WORDS_PER_ROW + (x>>LOG_WORD_SIZE)`, truncated to `LOG_MAX_ADDR`.
  - E_RD → E_WAIT.
  - E_WAIT: latch front `dout`, XOR bit `WORD_SIZE-1-x[LOG_WORD_SIZE-1:0]` (MSB = leftmost cell).
  - E_WR: front we=1, write the word, pulse `edit_ack_out`, → E_IDLE.
  - If `render_done_in` falls in E_RD/E_WAIT: abort to E_RD, retrying next blanking. E_WR always completes, with the renderer losing that cycle's read.
- Edit and step arriving in the same cycle: the edit wins, and gen stays IDLE until the edit returns to E_IDLE.

## Timing
- Read latency 1 cycle for all requesters; the block adds no pipeline register on the data path.
- Edit: request to ack takes 4 cycles when uninterrupted.
- Swap is visible to renderer reads on the cycle after READY → IDLE.
- Asynchronous reset mid-operation forces every state to its reset value immediately; memory contents are untouched.

## Configuration
- `BOARD_ARBITER_AUTO_STEP_EN` defined:
  - A frame counter increments on each rising edge of `render_done_in` while `run_in`=1.
  - At `STEP_FRAMES-1` it sets step pending and returns to 0.
  - `run_in`=0 clears the counter.
- Undefined: no counter; `run_in` is ignored and only `step_in` sets pending.

## Structure
- Shared package: `WORDS_PER_ROW`, `gen_state_t` (IDLE/RUN/READY), `edit_state_t` (E_IDLE/E_RD/E_WAIT/E_WR).
- Sub-module `cell_toggle_rmw`: edit FSM, address/bit computation, ack.

## Test plan
- Reset, `render_done_in`=0, `render_addr_in`=5 → `mem_a_addr_out`=5; A `dout` appears on `render_data_out` next cycle; `front_sel_out`=0.
- `step_in` pulse, blanking, `upd_done_in` after 10 cycles → one `upd_start_out` pulse, swap on next blanking cycle, `front_sel_out`=1, `gen_count_out`=1.
- Edit x=3,y=1 with word 0x0000 (WORD_SIZE=16, 4 words/row) → write address 4, data 0x1000; ack 4 cycles after request.
- Edit requested while gen RUN → no ack until after swap; then written to new front buffer.
- `render_done_in` falls during E_WAIT → no write; retried next blanking, single ack.
- With `BOARD_ARBITER_AUTO_STEP_EN`, `STEP_FRAMES`=2, `run_in`=1, 6 frames → exactly 3 `upd_start_out` pulses.
